// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter sharing one 256 x 16 memory between the fetch port and the LD/ST data port.
// One access is outstanding at a time; fetch starvation is bounded by a data-grant streak counter.
module mem_port_arbiter #(
  parameter int MEM_LAT    = 2,
  parameter int STREAK_MAX = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [7:0]  if_addr,
  input  logic        if_cancel,
  output logic        if_ack,
  output logic [15:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [7:0]  d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_ack,
  output logic [15:0] d_rdata,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        mem_en,
  output logic        mem_we,
  output logic [7:0]  mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_e;

  localparam logic [2:0] LAT  = 3'(MEM_LAT);
  localparam logic [3:0] SMAX = 4'(STREAK_MAX);

  state_e      state_q, state_d;
  logic        owner_if_q, owner_if_d;   // 1 = fetch owns the access
  logic        cancel_q, cancel_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [3:0]  streak_q, streak_d;
  logic [15:0] if_rdata_q, if_rdata_d;
  logic [15:0] d_rdata_q, d_rdata_d;
  logic        mem_en_q, mem_en_d;
  logic        mem_we_q, mem_we_d;
  logic [7:0]  mem_addr_q, mem_addr_d;
  logic [15:0] mem_wdata_q, mem_wdata_d;

  logic fetch_ok, grant_d, grant_f;

  assign fetch_ok = if_req & ~if_cancel;
  assign grant_d  = d_req & (~fetch_ok | (streak_q < SMAX));
  assign grant_f  = fetch_ok & ~grant_d;

  always_comb begin
    // NOTE: every _d gets a default first so no path leaves it unassigned and infers a latch.
    state_d     = state_q;
    owner_if_d  = owner_if_q;
    cancel_d    = cancel_q;
    cnt_d       = cnt_q;
    streak_d    = streak_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    mem_en_d    = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    unique case (state_q)
      ST_IDLE: begin
        cancel_d = 1'b0;
        if (grant_d) begin
          owner_if_d  = 1'b0;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          mem_en_d    = 1'b1;
          state_d     = ST_ISSUE;
          // Only data grants that make a fetch wait count toward the streak.
          if (!if_req)              streak_d = '0;
          else if (streak_q < SMAX) streak_d = streak_q + 4'd1;
        end else if (grant_f) begin
          owner_if_d  = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          mem_en_d    = 1'b1;
          streak_d    = '0;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = LAT;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == 3'd1) begin
          state_d = ST_DONE;
          if (owner_if_q) begin
            if (!cancel_q && !if_cancel) if_rdata_d = mem_rdata;
          end else if (!mem_we_q) begin
            d_rdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // A redirect abandons an owned fetch; the memory access itself still runs to completion.
    if (state_q != ST_IDLE && owner_if_q && if_cancel) cancel_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      owner_if_q  <= 1'b0;
      cancel_q    <= 1'b0;
      cnt_q       <= '0;
      streak_q    <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_if_q  <= owner_if_d;
      cancel_q    <= cancel_d;
      cnt_q       <= cnt_d;
      streak_q    <= streak_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign if_ack    = (state_q == ST_DONE) & owner_if_q & ~cancel_q & ~if_cancel;
  assign d_ack     = (state_q == ST_DONE) & ~owner_if_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign stall_if  = if_req & ~if_ack & ~if_cancel;
  assign stall_mem = d_req & ~d_ack;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural 2-cycle-latency memory model.
module tb_mem_port_arbiter;

  localparam int MEM_LAT    = 2;
  localparam int STREAK_MAX = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, if_cancel, if_ack, d_req, d_we, d_ack;
  logic [7:0]  if_addr, d_addr, mem_addr;
  logic [15:0] if_rdata, d_wdata, d_rdata, mem_wdata, mem_rdata;
  logic        stall_if, stall_mem, mem_en, mem_we;
  logic        preload;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    int          cycles;
    int          en;
    int          st;
    int          en_cyc;
    bit          seen;
    logic [15:0] data;
    logic        we;
    logic [7:0]  addr;
    logic [15:0] wdata;
  } acc_t;

  mem_port_arbiter #(.MEM_LAT(MEM_LAT), .STREAK_MAX(STREAK_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_cancel(if_cancel),
    .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: read data is valid only in the cycle MEM_LAT after mem_en.
  logic [15:0] mem [256];
  logic [15:0] rd1 = '0, rd2 = '0;
  logic        v1 = 1'b0, v2 = 1'b0;

  function automatic logic [15:0] init_val(input int a);
    case (a)
      0:       return 16'h1000;
      1:       return 16'h1001;
      2:       return 16'h1002;
      10:      return 16'hFFFC;
      32:      return 16'hABCD;
      8'h40:   return 16'h5A5A;
      8'h80:   return 16'h1234;
      default: return 16'(a) ^ 16'h7700;
    endcase
  endfunction

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
    end else if (mem_en && mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
    v1  <= mem_en & ~mem_we;
    rd1 <= mem[mem_addr];
    v2  <= v1;
    rd2 <= rd1;
  end
  assign mem_rdata = v2 ? rd2 : 16'hBAD0;

  // Runs from a negedge where the request is already driven until the requester's ack.
  task automatic run_access(input bit fetch, output acc_t r);
    r.cycles = 0; r.en = 0; r.st = 0; r.en_cyc = -1; r.seen = 1'b0;
    r.data = 'x; r.we = 'x; r.addr = 'x; r.wdata = 'x;
    while (!r.seen && r.cycles < 30) begin
      @(posedge clk);
      @(negedge clk);
      r.cycles++;
      if (mem_en) begin
        r.en++;
        r.en_cyc = cyc;
        r.we = mem_we; r.addr = mem_addr; r.wdata = mem_wdata;
      end
      if (fetch ? if_ack : d_ack) begin
        r.seen = 1'b1;
        r.data = fetch ? if_rdata : d_rdata;
      end else begin
        r.st += fetch ? int'(stall_if) : int'(stall_mem);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; preload = 1'b1;
    if_req = 1'b1; if_addr = '0; if_cancel = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    #2;
    checks++;
    if ({if_ack, d_ack, if_rdata, d_rdata, mem_en, mem_we, mem_addr, mem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h %h %h %h %h %h %h %h expected all zero",
               if_ack, d_ack, if_rdata, d_rdata, mem_en, mem_we, mem_addr, mem_wdata);
    end
    checks++;
    if (stall_if !== 1'b1) begin errors++; $display("FAIL reset_stall_if: got %b expected 1", stall_if); end
    checks++;
    if (stall_mem !== 1'b1) begin errors++; $display("FAIL reset_stall_mem: got %b expected 1", stall_mem); end
    if_cancel = 1'b1;
    #1;
    checks++;
    if (stall_if !== 1'b0) begin errors++; $display("FAIL reset_stall_if_cancel: got %b expected 0", stall_if); end
    if_req = 1'b0; if_cancel = 1'b0; d_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; preload = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({mem_en, d_ack, if_ack} !== 3'b000) begin
      errors++; $display("FAIL idle_quiet: got %b expected 000", {mem_en, d_ack, if_ack});
    end
  endtask

  task automatic test_single_load();
    acc_t r;
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'd10;
    run_access(1'b0, r);
    d_req = 1'b0;
    checks++;
    if (!r.seen || r.cycles != 4) begin errors++; $display("FAIL load_latency: got %0d (seen %b) expected 4", r.cycles, r.seen); end
    checks++;
    if (r.en != 1 || r.addr !== 8'd10 || r.we !== 1'b0) begin
      errors++; $display("FAIL load_issue: got en=%0d addr=%h we=%b expected 1/0a/0", r.en, r.addr, r.we);
    end
    checks++;
    if (r.st != 3) begin errors++; $display("FAIL load_stall_cycles: got %0d expected 3", r.st); end
    checks++;
    if (r.data !== 16'hFFFC) begin errors++; $display("FAIL load_data: got %h expected fffc", r.data); end
    @(negedge clk);
    checks++;
    if (d_ack !== 1'b0 || d_rdata !== 16'hFFFC) begin
      errors++; $display("FAIL load_ack_pulse: got ack=%b rdata=%h expected 0/fffc", d_ack, d_rdata);
    end
  endtask

  task automatic test_fetch_stream();
    acc_t r;
    int   prev_en;
    prev_en = 0;
    @(negedge clk);
    if_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if_addr = 8'(k);
      run_access(1'b1, r);
      checks++;
      if (!r.seen || r.cycles != ((k == 0) ? 4 : 5)) begin
        errors++; $display("FAIL fetch%0d_latency: got %0d (seen %b) expected %0d", k, r.cycles, r.seen, (k == 0) ? 4 : 5);
      end
      checks++;
      if (r.data !== 16'h1000 + 16'(k)) begin
        errors++; $display("FAIL fetch%0d_data: got %h expected %h", k, r.data, 16'h1000 + 16'(k));
      end
      if (k > 0) begin
        checks++;
        if (r.en_cyc - prev_en != 5) begin
          errors++; $display("FAIL fetch%0d_en_spacing: got %0d expected 5", k, r.en_cyc - prev_en);
        end
      end
      prev_en = r.en_cyc;
    end
    if_req = 1'b0;
  endtask

  task automatic test_contention();
    logic [7:0] order;
    int         n, t;
    order = '0; n = 0; t = 0;
    @(negedge clk);
    if_addr = 8'h40; d_addr = 8'h80; d_we = 1'b0;
    if_req = 1'b1; d_req = 1'b1;
    while (n < 8 && t < 80) begin
      @(posedge clk);
      @(negedge clk);
      t++;
      if (mem_en) begin
        order[n] = (mem_addr == 8'h40);
        n++;
      end
    end
    repeat (3) @(negedge clk);
    checks++;
    if (n != 8 || order !== 8'b1000_1000) begin
      errors++; $display("FAIL contention_order: got %b (%0d grants, bit0 first, 1=F) expected 10001000", order, n);
    end
    checks++;
    if (if_ack !== 1'b1 || if_rdata !== 16'h5A5A || d_rdata !== 16'h1234) begin
      errors++; $display("FAIL contention_final: got ack=%b if=%h d=%h expected 1/5a5a/1234", if_ack, if_rdata, d_rdata);
    end
    if_req = 1'b0; d_req = 1'b0;
  endtask

  task automatic test_cancel();
    int acks;
    acks = 0;
    @(negedge clk);
    if_req = 1'b1; if_addr = 8'd32;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (mem_en !== 1'b1 || mem_addr !== 8'd32 || stall_if !== 1'b1) begin
      errors++; $display("FAIL cancel_issue: got en=%b addr=%h stall=%b expected 1/20/1", mem_en, mem_addr, stall_if);
    end
    @(posedge clk);
    @(negedge clk);
    if_cancel = 1'b1;
    #1;
    checks++;
    if (stall_if !== 1'b0) begin errors++; $display("FAIL cancel_stall_if: got %b expected 0", stall_if); end
    @(negedge clk);
    if_cancel = 1'b0; if_req = 1'b0;
    if (if_ack) acks++;
    repeat (5) begin
      @(negedge clk);
      if (if_ack) acks++;
    end
    checks++;
    if (acks != 0) begin errors++; $display("FAIL cancel_no_ack: got %0d acks expected 0", acks); end
    checks++;
    if (if_rdata !== 16'h5A5A) begin errors++; $display("FAIL cancel_rdata_kept: got %h expected 5a5a", if_rdata); end
  endtask

  task automatic test_store_load();
    acc_t r;
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 8'd0; d_wdata = 16'hFFF8;
    run_access(1'b0, r);
    checks++;
    if (!r.seen || r.cycles != 4) begin errors++; $display("FAIL store_latency: got %0d (seen %b) expected 4", r.cycles, r.seen); end
    checks++;
    if (r.we !== 1'b1 || r.addr !== 8'd0 || r.wdata !== 16'hFFF8) begin
      errors++; $display("FAIL store_issue: got we=%b addr=%h wdata=%h expected 1/00/fff8", r.we, r.addr, r.wdata);
    end
    checks++;
    if (r.data !== 16'h1234) begin errors++; $display("FAIL store_keeps_rdata: got %h expected 1234", r.data); end
    d_we = 1'b0;
    run_access(1'b0, r);
    d_req = 1'b0;
    checks++;
    if (!r.seen || r.cycles != 5) begin errors++; $display("FAIL load_after_store_latency: got %0d expected 5", r.cycles); end
    checks++;
    if (r.data !== 16'hFFF8) begin errors++; $display("FAIL load_after_store_data: got %h expected fff8", r.data); end
  endtask

  task automatic test_async_reset();
    acc_t r;
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'd10;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({if_ack, d_ack, if_rdata, d_rdata, mem_en, mem_we, mem_addr, mem_wdata} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got %h %h %h %h %h %h %h %h expected all zero",
               if_ack, d_ack, if_rdata, d_rdata, mem_en, mem_we, mem_addr, mem_wdata);
    end
    checks++;
    if (stall_mem !== 1'b1) begin errors++; $display("FAIL midreset_stall_mem: got %b expected 1", stall_mem); end
    @(negedge clk);
    rst_n = 1'b1;
    run_access(1'b0, r);
    d_req = 1'b0;
    checks++;
    if (!r.seen || r.cycles != 4 || r.en != 1) begin
      errors++; $display("FAIL reserve_latency: got %0d cycles en=%0d (seen %b) expected 4/1", r.cycles, r.en, r.seen);
    end
    checks++;
    if (r.data !== 16'hFFFC) begin errors++; $display("FAIL reserve_data: got %h expected fffc", r.data); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_load();
    test_fetch_stream();
    test_contention();
    test_cancel();
    test_store_load();
    test_async_reset();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
